// File: rtl/bgr_startup_seq_if.sv
// Control/status bundle between the bandgap startup sequencer and its user.
// The master side drives the request and the raw bandgap flag; the slave side is the sequencer.
interface bgr_startup_seq_if;
    logic       enable;
    logic       vbg;
    logic       porst;
    logic       bgr_ready;
    logic       fault;
    logic       dropout;
    logic [1:0] retry_cnt;

    modport master (
        output enable,
        output vbg,
        input  porst,
        input  bgr_ready,
        input  fault,
        input  dropout,
        input  retry_cnt
    );

    modport slave (
        input  enable,
        input  vbg,
        output porst,
        output bgr_ready,
        output fault,
        output dropout,
        output retry_cnt
    );
endinterface

// File: rtl/bgr_startup_seq.sv
// Bandgap startup sequencer: pulses porst, waits for vbg, requires a settle window before ready,
// retries on timeout and flags a sticky fault or dropout.
module bgr_startup_seq #(
    parameter int unsigned PORST_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_RETRY      = 3
) (
    input logic              wb_clk_i,
    input logic              rst_n,
    bgr_startup_seq_if.slave bus_io
);

    typedef enum logic [2:0] {
        StIdle,
        StPulse,
        StWaitVbg,
        StSettle,
        StReady,
        StFault
    } state_e;

    localparam logic [15:0] PulseLast = 16'(PORST_CYCLES - 1);
    localparam logic [15:0] TmoLast   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] SettleEnd = 16'(SETTLE_CYCLES);
    localparam logic [1:0]  RetryMax  = 2'(MAX_RETRY);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  retry_q, retry_d;
    logic        porst_q, porst_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic        dropout_q, dropout_d;
    logic        vbg_meta_q, vbg_s_q;

    // vbg is asynchronous to wb_clk_i; only the second flop feeds the FSM.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vbg_meta_q <= 1'b0;
            vbg_s_q    <= 1'b0;
        end else begin
            vbg_meta_q <= bus_io.vbg;
            vbg_s_q    <= vbg_meta_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            retry_q   <= '0;
            porst_q   <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            dropout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            porst_q   <= porst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            dropout_q <= dropout_d;
        end
    end

    // One shared counter serves pulse width, timeout and settle; every transition clears it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        porst_d   = 1'b0;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        dropout_d = dropout_q;

        if (!bus_io.enable) begin
            state_d   = StIdle;
            cnt_d     = '0;
            retry_d   = '0;
            dropout_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StPulse;
                    cnt_d     = '0;
                    retry_d   = '0;
                    dropout_d = 1'b0;
                    porst_d   = 1'b1;
                end
                StPulse: begin
                    if (cnt_q == PulseLast) begin
                        state_d = StWaitVbg;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                        porst_d = 1'b1;
                    end
                end
                StWaitVbg: begin
                    // A rising vbg_s wins over a coincident timeout.
                    if (vbg_s_q) begin
                        state_d = StSettle;
                        cnt_d   = '0;
                    end else if (cnt_q == TmoLast) begin
                        cnt_d = '0;
                        if (retry_q < RetryMax) begin
                            state_d = StPulse;
                            retry_d = retry_q + 2'd1;
                            porst_d = 1'b1;
                        end else begin
                            state_d = StFault;
                            fault_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StSettle: begin
                    if (!vbg_s_q) begin
                        state_d = StWaitVbg;
                        cnt_d   = '0;
                    end else if (cnt_q == SettleEnd) begin
                        state_d = StReady;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StReady: begin
                    if (!vbg_s_q) begin
                        state_d   = StWaitVbg;
                        cnt_d     = '0;
                        dropout_d = 1'b1;
                    end else begin
                        ready_d = 1'b1;
                    end
                end
                StFault: begin
                    fault_d = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus_io.porst     = porst_q;
    assign bus_io.bgr_ready = ready_q;
    assign bus_io.fault     = fault_q;
    assign bus_io.dropout   = dropout_q;
    assign bus_io.retry_cnt = retry_q;

endmodule

// File: tb/tb_bgr_startup_seq.sv
// Directed bench for bgr_startup_seq at default parameters; expectations go through a
// scoreboard queue and are compared with immediate assertions.
module tb_bgr_startup_seq;

    logic wb_clk_i = 1'b0;
    logic rst_n;

    bgr_startup_seq_if bus ();

    bgr_startup_seq dut (
        .wb_clk_i (wb_clk_i),
        .rst_n    (rst_n),
        .bus_io   (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    logic [31:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hdead_beef;
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk_outs(input string tag, input int p, input int r, input int f,
                            input int d, input int rc);
        expect_val(p);
        expect_val(r);
        expect_val(f);
        expect_val(d);
        expect_val(rc);
        chk({tag, ".porst"}, 32'(bus.porst));
        chk({tag, ".bgr_ready"}, 32'(bus.bgr_ready));
        chk({tag, ".fault"}, 32'(bus.fault));
        chk({tag, ".dropout"}, 32'(bus.dropout));
        chk({tag, ".retry_cnt"}, 32'(bus.retry_cnt));
    endtask

    // porst was seen high just after an edge; count edges until it drops.
    task automatic measure_high(output int n);
        n = 0;
        repeat (100) begin
            step();
            n++;
            if (bus.porst !== 1'b1) return;
        end
    endtask

    // Edge index (first edge = 0) at which bgr_ready is seen high.
    task automatic wait_ready(input int limit, output int n);
        n = 0;
        repeat (limit) begin
            step();
            if (bus.bgr_ready === 1'b1) return;
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fall;
        int first;
        int g;
        int cnt;
        int sz;

        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.vbg    = 1'b0;
        repeat (3) step();
        chk_outs("reset", 0, 0, 0, 0, 0);
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        step();
        chk_outs("idle", 0, 0, 0, 0, 0);

        // Nominal startup
        bus.enable = 1'b1;
        step();
        expect_val(1);
        chk("nom.porst_rise", 32'(bus.porst));
        expect_val(16);
        measure_high(n);
        chk("nom.porst_width", n);
        repeat (5) step();
        bus.vbg = 1'b1;
        expect_val(67);
        wait_ready(200, n);
        chk("nom.ready_latency", n);
        chk_outs("nom.ready", 0, 1, 0, 0, 0);

        // Dropout while ready: vbg low for three clocks
        bus.vbg = 1'b0;
        fall = -1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (fall < 0 && bus.bgr_ready === 1'b0) fall = i;
        end
        bus.vbg = 1'b1;
        expect_val(2);
        chk("drop.fall_edge", fall);
        expect_val(1);
        chk("drop.dropout_set", 32'(bus.dropout));
        expect_val(67);
        wait_ready(200, n);
        chk("drop.rearm_latency", n);
        chk_outs("drop.sticky", 0, 1, 0, 1, 0);

        bus.enable = 1'b0;
        step();
        chk_outs("drop.idle_clear", 0, 0, 0, 0, 0);
        bus.vbg = 1'b0;
        repeat (3) step();

        // Settle glitch: 30 high, 1 low, then high
        bus.enable = 1'b1;
        step();
        expect_val(16);
        measure_high(n);
        chk("glitch.porst_width", n);
        repeat (5) step();
        first = -1;
        for (int i = 0; i < 200; i++) begin
            bus.vbg = (i == 30) ? 1'b0 : 1'b1;
            step();
            if (bus.bgr_ready === 1'b1) begin
                first = i;
                break;
            end
        end
        expect_val(98);
        chk("glitch.ready_edge", first);
        chk_outs("glitch.ready", 0, 1, 0, 0, 0);

        bus.enable = 1'b0;
        step();
        bus.vbg = 1'b0;
        repeat (3) step();

        // Enable dropped during SETTLE
        bus.enable = 1'b1;
        step();
        expect_val(16);
        measure_high(n);
        chk("endrop.porst_width", n);
        bus.vbg = 1'b1;
        repeat (10) step();
        bus.enable = 1'b0;
        step();
        chk_outs("endrop.idle", 0, 0, 0, 0, 0);
        cnt = 0;
        repeat (20) begin
            step();
            if (bus.porst !== 1'b0 || bus.bgr_ready !== 1'b0) cnt++;
        end
        expect_val(0);
        chk("endrop.quiet_edges", cnt);
        bus.enable = 1'b1;
        step();
        expect_val(1);
        chk("endrop.repulse", 32'(bus.porst));
        bus.enable = 1'b0;
        step();
        bus.vbg = 1'b0;
        repeat (3) step();

        // Timeout to fault with vbg held low
        for (int k = 0; k < 4; k++) begin
            expect_val(16);
            expect_val(1024);
            if (k < 3) expect_val(k + 1);
        end
        bus.enable = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            measure_high(n);
            chk("tmo.porst_width", n);
            g = 0;
            repeat (2000) begin
                step();
                g++;
                if (bus.porst === 1'b1 || bus.fault === 1'b1) break;
            end
            chk("tmo.wait_gap", g);
            if (k < 3) chk("tmo.retry_cnt", 32'(bus.retry_cnt));
        end
        chk_outs("tmo.fault", 0, 0, 1, 0, 3);
        cnt = 0;
        repeat (50) begin
            step();
            if (bus.fault === 1'b1 && bus.porst === 1'b0) cnt++;
        end
        expect_val(50);
        chk("tmo.fault_hold", cnt);
        bus.enable = 1'b0;
        step();
        chk_outs("tmo.clear", 0, 0, 0, 0, 0);
        repeat (2) step();

        // Reset mid-pulse drops porst with no clock edge
        bus.enable = 1'b1;
        step();
        repeat (8) step();
        #2;
        rst_n = 1'b0;
        #1;
        expect_val(0);
        chk("rst.porst_async", 32'(bus.porst));
        #1;
        rst_n = 1'b1;
        step();
        expect_val(1);
        chk("rst.repulse_rise", 32'(bus.porst));
        expect_val(16);
        measure_high(n);
        chk("rst.porst_width", n);

        sz = exp_q.size();
        expect_val(0);
        chk("sb.drain", sz);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bgr_startup_seq.md
BGR_STARTUP_SEQ -- requirements
Module: bgr_startup_seq

Interface
REQ-001 SHALL have parameter PORST_CYCLES, default 16, the porst pulse width in clocks (legal range 1..255).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 64, the consecutive clocks vbg must stay high before ready (legal range 1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the clocks allowed per attempt for vbg to rise (legal range 1..65535).
REQ-004 SHALL have parameter MAX_RETRY, default 3, the re-pulse attempts before fault (legal range 0..3).
REQ-005 SHALL have port wb_clk_i, input, width 1, the single clock.
REQ-006 SHALL have port rst_n, input, width 1, the reset: asynchronous, active-low.
REQ-007 SHALL have port enable, input, width 1, which requests the bandgap startup while high (synchronous level).
REQ-008 SHALL have port vbg, input, width 1, the bandgap output; it is asynchronous to wb_clk_i.
REQ-009 SHALL have port porst, output, width 1, the power-on reset pulse to the bandgap.
REQ-010 SHALL have port bgr_ready, output, width 1, which indicates the reference is settled and valid.
REQ-011 SHALL have port fault, output, width 1, which indicates startup failed after all retries; it is sticky.
REQ-012 SHALL have port retry_cnt, output, width 2, the number of re-pulses issued in the current enable session.
REQ-013 SHALL have port dropout, output, width 1, which latches when vbg is lost while READY; it is sticky.

Function
REQ-014 SHALL pass vbg through a 2-flop synchronizer (vbg_s); all decisions SHALL use vbg_s only.
REQ-015 SHALL drive every output from a register; no output SHALL be combinational.
REQ-016 SHALL implement states IDLE, PULSE, WAIT_VBG, SETTLE, READY, FAULT.
REQ-017 SHALL, in IDLE with enable=1, enter PULSE on the next edge and clear all counters.
REQ-018 SHALL hold porst=1 for exactly PORST_CYCLES clocks while in PULSE, then enter WAIT_VBG with porst=0.
REQ-019 SHALL, in WAIT_VBG, increment a 16-bit timeout counter each clock; when vbg_s=1, enter SETTLE and clear the counter.
REQ-020 SHALL, in WAIT_VBG when the timeout counter reaches TIMEOUT_CYCLES with vbg_s=0, re-enter PULSE and increment retry_cnt if retry_cnt<MAX_RETRY; otherwise enter FAULT.
REQ-021 SHALL, when vbg_s=1 and the timeout terminal count coincide in the same cycle, give precedence to vbg_s and enter SETTLE.
REQ-022 SHALL, in SETTLE, count consecutive vbg_s=1 clocks; on reaching SETTLE_CYCLES, enter READY with bgr_ready=1.
REQ-023 SHALL, if vbg_s=0 during SETTLE, return to WAIT_VBG with the settle and timeout counters cleared; retry_cnt SHALL be unchanged.
REQ-024 SHALL, in READY with vbg_s=0, deassert bgr_ready on the next edge, set dropout=1, and enter WAIT_VBG with counters cleared.
REQ-025 SHALL, in FAULT, hold fault=1, porst=0, bgr_ready=0, and remain there until enable=0.
REQ-026 SHALL, when enable=0 in any state, enter IDLE on the next edge: porst=0, bgr_ready=0, retry_cnt=0, fault=0, dropout=0.
REQ-027 SHALL saturate retry_cnt at MAX_RETRY and never wrap it.
REQ-028 SHALL size all counters so that they never overflow for legal parameter values.

Reset
REQ-029 SHALL, on rst_n=0, immediately and asynchronously force state IDLE, porst=0, bgr_ready=0, fault=0, dropout=0, retry_cnt=0, all counters 0, and both synchronizer flops 0.
REQ-030 SHALL, on rst_n=0 mid-PULSE, drop porst asynchronously without completing the pulse.
REQ-031 SHALL release reset synchronously, taking effect on the first wb_clk_i edge after rst_n rises; the first transition after release SHALL require enable=1 sampled on an edge.

Verification (default parameters)
REQ-032 SHALL cover the nominal case: enable=1 at edge 0, vbg driven high 5 clocks after porst falls and held -> porst high for exactly 16 clocks, bgr_ready rises 67 edges after the first edge sampling vbg high, and retry_cnt=0.
REQ-033 SHALL cover the timeout/fault case: vbg held 0 -> porst pulses 4 times, separated by 1024 WAIT_VBG clocks, retry_cnt reaches 3, then fault=1 and stays high; lowering enable clears fault next edge.
REQ-034 SHALL cover the settle glitch case: vbg high for 30 clocks, low for 1 clock, then high -> state returns to WAIT_VBG, bgr_ready rises only after 64 fresh consecutive clocks, and retry_cnt=0.
REQ-035 SHALL cover the dropout case: in READY, vbg low for 3 clocks, then high -> bgr_ready falls within 3 edges, dropout=1 sticky, and bgr_ready re-asserts after 64 settle clocks.
REQ-036 SHALL cover the reset mid-pulse case: rst_n low at PULSE clock 8 -> porst=0 immediately, with no wb_clk_i edge required; after release with enable=1, a full 16-clock pulse is issued.
REQ-037 SHALL cover the enable-drop case: enable dropped while in SETTLE -> IDLE next edge, all outputs 0, and no porst pulse until enable is high again.
